// File: rtl/uart_pkg.sv
// Shared definitions for the two-byte PC response transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    START  = 2'd1,
    DADOS  = 2'd2,
    STOP   = 2'd3
  } estadoT;

  localparam int BITS_POR_BYTE       = 8;
  localparam int BYTES_POR_QUADRO    = 2;
  localparam int CLKS_PER_BIT_PADRAO = 5208;

  // Frame image as loaded into the shift register: code byte leaves first.
  function automatic logic [15:0] montaQuadro(input logic [7:0] codigo,
                                              input logic [7:0] dado);
    return {dado, codigo};
  endfunction

endpackage

// File: rtl/gerador_baud.sv
// Bit-period timer: free-running modulo-CLKS_PER_BIT counter that can be
// restarted so that a new frame's first bit gets a full period.
module gerador_baud
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  output logic tick
);

  localparam int LARGURA = $clog2(CLKS_PER_BIT);
  localparam logic [LARGURA-1:0] ULTIMO = LARGURA'(CLKS_PER_BIT - 1);

  logic [LARGURA-1:0] contagem;

  // Count 0..CLKS_PER_BIT-1, wrapping; a clear forces the count back to 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem <= '0;
    end else if (limpa || contagem == ULTIMO) begin
      contagem <= '0;
    end else begin
      contagem <= contagem + LARGURA'(1);
    end
  end

  assign tick = (contagem == ULTIMO);

endmodule

// File: rtl/uart_tx_quadro.sv
// Two-byte 8N1 response transmitter: code byte then data byte, back to back.
//
// Handshake: iniciar is a request qualified only by the FSM being idle
// (ocupado low). A request seen at a rising edge while idle is accepted on
// that edge and both bytes are captured; requests while busy are dropped,
// never queued. concluido pulses for one cycle as the line returns to idle,
// and a request held through that cycle starts the next frame immediately.
module uart_tx_quadro
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [7:0] byteCodigo,
  input  logic [7:0] byteDado,
  output logic       ocupado,
  output logic       bitSerialTX,
  output logic       concluido,
  output logic [1:0] estadoDbg
);

  localparam logic [2:0] ULTIMO_BIT  = 3'(BITS_POR_BYTE - 1);
  localparam logic       ULTIMO_BYTE = 1'(BYTES_POR_QUADRO - 1);

  estadoT      estado, estadoProx;
  logic [15:0] desloc, deslocProx;
  logic [2:0]  contBits, contBitsProx;
  logic        indiceByte, indiceByteProx;
  logic        txReg, txProx;
  logic        ocupadoReg, ocupadoProx;
  logic        concluidoReg, concluidoProx;
  logic        aceita;
  logic        tick;

  assign aceita = (estado == OCIOSO) && iniciar;

  gerador_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uBaud (
    .clock(clock),
    .reset(reset),
    .limpa(aceita),
    .tick (tick)
  );

  // State and output registers; the line is high straight out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= OCIOSO;
      desloc       <= '0;
      contBits     <= '0;
      indiceByte   <= 1'b0;
      txReg        <= 1'b1;
      ocupadoReg   <= 1'b0;
      concluidoReg <= 1'b0;
    end else begin
      estado       <= estadoProx;
      desloc       <= deslocProx;
      contBits     <= contBitsProx;
      indiceByte   <= indiceByteProx;
      txReg        <= txProx;
      ocupadoReg   <= ocupadoProx;
      concluidoReg <= concluidoProx;
    end
  end

  // Next state and next line value; all bit boundaries land on baud ticks.
  always_comb begin
    estadoProx     = estado;
    deslocProx     = desloc;
    contBitsProx   = contBits;
    indiceByteProx = indiceByte;
    txProx         = txReg;
    ocupadoProx    = ocupadoReg;
    concluidoProx  = 1'b0;
    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          estadoProx     = START;
          deslocProx     = montaQuadro(byteCodigo, byteDado);
          contBitsProx   = '0;
          indiceByteProx = 1'b0;
          txProx         = 1'b0;
          ocupadoProx    = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          estadoProx = DADOS;
          txProx     = desloc[0];
        end
      end
      DADOS: begin
        if (tick) begin
          // Each tick retires the bit on the line; after eight the next
          // byte already sits in the low end of the register.
          deslocProx = {1'b0, desloc[15:1]};
          if (contBits == ULTIMO_BIT) begin
            estadoProx   = STOP;
            contBitsProx = '0;
            txProx       = 1'b1;
          end else begin
            contBitsProx = contBits + 3'd1;
            txProx       = desloc[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (indiceByte != ULTIMO_BYTE) begin
            estadoProx     = START;
            indiceByteProx = 1'b1;
            txProx         = 1'b0;
          end else begin
            estadoProx    = OCIOSO;
            ocupadoProx   = 1'b0;
            concluidoProx = 1'b1;
            txProx        = 1'b1;
          end
        end
      end
      default: begin
        estadoProx = OCIOSO;
      end
    endcase
  end

  assign bitSerialTX = txReg;
  assign ocupado     = ocupadoReg;
  assign concluido   = concluidoReg;
  assign estadoDbg   = estado;

endmodule

// File: tb/tb_uart_tx_quadro.sv
// Bench for uart_tx_quadro: a UART receiver model checks serialized bytes
// against an expected queue; frame timing is measured per frame.
module tb_uart_tx_quadro;

  localparam int CPB_A = 4;
  localparam int CPB_B = 7;

  logic       clock;
  logic       reset;
  logic       iniciar, iniciarB;
  logic [7:0] byteCodigo, byteDado, byteCodigoB, byteDadoB;
  logic       ocupado, bitSerialTX, concluido;
  logic       ocupadoB, bitSerialTXB, concluidoB;
  logic [1:0] estadoDbg, estadoDbgB;

  logic [7:0] exp_q[$];

  int nTestes = 0;
  int nFalhas = 0;
  int ciclo = 0;
  int nConc = 0;
  int ultimoConc = 0;
  int penultimoConc = 0;

  int   nOcup, posConc, base;
  logic txFim;

  uart_tx_quadro #(.CLKS_PER_BIT(CPB_A)) dut (
    .clock      (clock),
    .reset      (reset),
    .iniciar    (iniciar),
    .byteCodigo (byteCodigo),
    .byteDado   (byteDado),
    .ocupado    (ocupado),
    .bitSerialTX(bitSerialTX),
    .concluido  (concluido),
    .estadoDbg  (estadoDbg)
  );

  uart_tx_quadro #(.CLKS_PER_BIT(CPB_B)) dutB (
    .clock      (clock),
    .reset      (reset),
    .iniciar    (iniciarB),
    .byteCodigo (byteCodigoB),
    .byteDado   (byteDadoB),
    .ocupado    (ocupadoB),
    .bitSerialTX(bitSerialTXB),
    .concluido  (concluidoB),
    .estadoDbg  (estadoDbgB)
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: obtido=timeout esperado=fim");
    $fatal(1, "watchdog");
  end

  always @(posedge clock) ciclo <= ciclo + 1;

  always @(negedge clock) begin
    if (concluido === 1'b1) begin
      nConc         <= nConc + 1;
      penultimoConc <= ultimoConc;
      ultimoConc    <= ciclo;
    end
  end

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    nTestes++;
    if (obs !== esp) begin
      nFalhas++;
      $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, esp);
    end
  endtask

  // Driver: one-cycle request; expected bytes go to the scoreboard
  task automatic enviaQuadro(input logic [7:0] codigo, input logic [7:0] dado);
    @(negedge clock);
    byteCodigo = codigo;
    byteDado   = dado;
    iniciar    = 1'b1;
    exp_q.push_back(codigo);
    exp_q.push_back(dado);
    @(posedge clock);
    #1 iniciar = 1'b0;
    verifica("linhaStart", bitSerialTX, 1'b0);
  endtask

  // Measures a frame from the cycle after acceptance until ocupado drops
  task automatic medeQuadro(output int nO, output int pC, output logic tF);
    nO = 0;
    pC = -1;
    tF = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (ocupado === 1'b1) nO++;
      if (concluido === 1'b1 && pC < 0) pC = k;
      if (ocupado !== 1'b1) begin
        tF = bitSerialTX;
        break;
      end
    end
  endtask

  task automatic rxEspera(input int n, output bit abortou);
    abortou = 1'b0;
    repeat (n) begin
      @(negedge clock);
      if (reset !== 1'b1) abortou = 1'b1;
    end
  endtask

  // Receiver model: mid-bit sampling of 8N1 characters on the A line
  initial begin
    logic [7:0] rxByte;
    logic       inicioBit, stopBit;
    bit         ab, abx;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && bitSerialTX === 1'b0) begin
        rxEspera(CPB_A / 2, ab);
        inicioBit = bitSerialTX;
        for (int i = 0; i < 8; i++) begin
          rxEspera(CPB_A, abx);
          ab = ab | abx;
          rxByte[i] = bitSerialTX;
        end
        rxEspera(CPB_A, abx);
        ab = ab | abx;
        stopBit = bitSerialTX;
        if (!ab) begin
          verifica("rxStartBit", inicioBit, 1'b0);
          verifica("rxStopBit", stopBit, 1'b1);
          verifica("rxFilaTemItem", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) verifica("rxByte", rxByte, exp_q.pop_front());
        end
      end
    end
  end

  // Stimulus sequence
  initial begin
    logic        linhaBaixa;
    logic [19:0] bitsB, lidoB;
    int          nOcupB, posConcB;

    reset = 1'b0;
    iniciar = 1'b0; byteCodigo = '0; byteDado = '0;
    iniciarB = 1'b0; byteCodigoB = '0; byteDadoB = '0;

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    verifica("rstTx", bitSerialTX, 1'b1);
    verifica("rstOcupado", ocupado, 1'b0);
    verifica("rstConcluido", concluido, 1'b0);
    verifica("rstEstado", estadoDbg, 2'd0);
    @(negedge clock) reset = 1'b1;
    linhaBaixa = 1'b0;
    repeat (50) begin
      @(negedge clock);
      if (bitSerialTX !== 1'b1 || ocupado !== 1'b0 || concluido !== 1'b0) linhaBaixa = 1'b1;
    end
    verifica("ociosoEstavel", linhaBaixa, 1'b0);

    // Single frame
    base = nConc;
    enviaQuadro(8'hA5, 8'h3C);
    medeQuadro(nOcup, posConc, txFim);
    verifica("simplesOcupado", nOcup, 80);
    verifica("simplesConcluido", posConc, 80);
    verifica("simplesTxFim", txFim, 1'b1);
    repeat (3) @(negedge clock);
    verifica("simplesNConc", nConc - base, 1);

    // Ignored start mid-frame with changed data
    base = nConc;
    enviaQuadro(8'hA5, 8'h3C);
    fork
      medeQuadro(nOcup, posConc, txFim);
      begin
        repeat (30) @(negedge clock);
        byteDado = 8'hFF;
        iniciar  = 1'b1;
        @(negedge clock);
        iniciar  = 1'b0;
      end
    join
    verifica("ignoraOcupado", nOcup, 80);
    verifica("ignoraConcluido", posConc, 80);
    repeat (3) @(negedge clock);
    verifica("ignoraNConc", nConc - base, 1);

    // Back-to-back with iniciar held high
    base = nConc;
    @(negedge clock);
    byteCodigo = 8'h00;
    byteDado   = 8'hFF;
    iniciar    = 1'b1;
    repeat (2) begin
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
    end
    @(posedge clock);
    #1 verifica("b2bStart1", bitSerialTX, 1'b0);
    medeQuadro(nOcup, posConc, txFim);
    verifica("b2bOcupado1", nOcup, 80);
    verifica("b2bConcluido1", posConc, 80);
    verifica("b2bGapAlto", txFim, 1'b1);
    @(posedge clock);
    #1 iniciar = 1'b0;
    verifica("b2bStart2", bitSerialTX, 1'b0);
    medeQuadro(nOcup, posConc, txFim);
    verifica("b2bOcupado2", nOcup, 80);
    verifica("b2bConcluido2", posConc, 80);
    repeat (3) @(negedge clock);
    verifica("b2bNConc", nConc - base, 2);
    verifica("b2bIntervalo", ultimoConc - penultimoConc, 81);

    // Reset mid-frame
    base = nConc;
    enviaQuadro(8'h12, 8'h34);
    repeat (37) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    verifica("rstMeioTx", bitSerialTX, 1'b1);
    verifica("rstMeioOcupado", ocupado, 1'b0);
    verifica("rstMeioEstado", estadoDbg, 2'd0);
    repeat (3) @(negedge clock);
    exp_q.delete();
    reset = 1'b1;
    repeat (5) @(negedge clock);
    verifica("rstMeioNConc", nConc - base, 0);
    verifica("rstMeioLinha", bitSerialTX, 1'b1);
    base = nConc;
    enviaQuadro(8'h01, 8'h80);
    medeQuadro(nOcup, posConc, txFim);
    verifica("posRstOcupado", nOcup, 80);
    verifica("posRstConcluido", posConc, 80);
    repeat (3) @(negedge clock);
    verifica("posRstNConc", nConc - base, 1);

    // Non-power-of-two divider on the second instance
    bitsB = {1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0};
    lidoB = '0;
    nOcupB = 0;
    posConcB = -1;
    @(negedge clock);
    byteCodigoB = 8'h55;
    byteDadoB   = 8'hAA;
    iniciarB    = 1'b1;
    @(posedge clock);
    #1 iniciarB = 1'b0;
    byteCodigoB = 8'h00;
    byteDadoB   = 8'h00;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (k % CPB_B == CPB_B / 2 && k / CPB_B < 20) lidoB[k / CPB_B] = bitSerialTXB;
      if (ocupadoB === 1'b1) nOcupB++;
      if (concluidoB === 1'b1 && posConcB < 0) posConcB = k;
      if (ocupadoB !== 1'b1) break;
    end
    verifica("divLinha", lidoB, bitsB);
    verifica("divOcupado", nOcupB, 20 * CPB_B);
    verifica("divConcluido", posConcB, 20 * CPB_B);

    repeat (20) @(negedge clock);
    verifica("filaVazia", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", nTestes, nFalhas);
    $finish;
  end

endmodule
